// File: rtl/arb_three_pkg.sv
// Shared router definitions for the output-side merge block: flit layout,
// flit type encodings, port identifiers, requester indices and FSM states.
package arb_three_pkg;

   localparam int DATA_WIDTH = 32;
   localparam int TYPE_MSB   = DATA_WIDTH - 1;
   localparam int TYPE_LSB   = DATA_WIDTH - 2;

   localparam logic [1:0] HEAD = 2'b01;
   localparam logic [1:0] BODY = 2'b10;
   localparam logic [1:0] TAIL = 2'b11;

   localparam logic [2:0] LOCAL = 3'd0;
   localparam logic [2:0] NORTH = 3'd1;
   localparam logic [2:0] EAST  = 3'd2;
   localparam logic [2:0] SOUTH = 3'd3;
   localparam logic [2:0] WEST  = 3'd4;

   typedef enum logic [1:0] {
      REQ_A = 2'd0,
      REQ_B = 2'd1,
      REQ_C = 2'd2
   } reqIdx_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_LOCK = 1'b1
   } arbState_t;

   function automatic logic [1:0] flitType(input logic [DATA_WIDTH-1:0] flit);
      return flit[TYPE_MSB:TYPE_LSB];
   endfunction

   // Adds two requester indices modulo three; never produces the value 3.
   function automatic logic [1:0] wrap3(input logic [1:0] base, input logic [1:0] off);
      logic [2:0] sum;
      sum = {1'b0, base} + {1'b0, off};
      if (sum >= 3'd3) begin
         sum = sum - 3'd3;
      end
      return sum[1:0];
   endfunction

endpackage

// File: rtl/arb_three_pick.sv
// rr_pick3: combinational three-way picker. Searches the request vector
// cyclically from the pointer (round-robin) or from A (fixed priority).
module rr_pick3
   import arb_three_pkg::*;
(
   input  logic [2:0] i_req,
   input  logic [1:0] i_ptr,
   input  logic       i_rr_en,
   output logic [2:0] o_gnt_onehot,
   output logic [1:0] o_gnt_idx,
   output logic       o_any
);

   logic [1:0] w_start;
   logic [1:0] w_cand;

   // A stray pointer value of 3 is treated as A so the search stays in range.
   assign w_start = (i_rr_en && (i_ptr != 2'd3)) ? i_ptr : 2'd0;

   // Take the first requester found walking start, start+1, start+2 (mod 3).
   always_comb begin
      o_gnt_onehot = 3'b000;
      o_gnt_idx    = 2'd0;
      o_any        = 1'b0;
      w_cand       = 2'd0;
      for (int k = 0; k < 3; k++) begin
         w_cand = wrap3(w_start, 2'(k));
         if (!o_any && i_req[w_cand]) begin
            o_any                = 1'b1;
            o_gnt_idx            = w_cand;
            o_gnt_onehot[w_cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/arb_three.sv
// arb_three: merges three wormhole input channels onto one output port
// through a single output register. A winner owns the port until its TAIL.
module arb_three
   import arb_three_pkg::*;
#(
   parameter int         RR_EN  = 1,
   parameter logic [2:0] OUT_ID = LOCAL
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic [DATA_WIDTH-1:0] A_data_i,
   input  logic                  A_valid_i,
   output logic                  A_ready_o,
   input  logic [DATA_WIDTH-1:0] B_data_i,
   input  logic                  B_valid_i,
   output logic                  B_ready_o,
   input  logic [DATA_WIDTH-1:0] C_data_i,
   input  logic                  C_valid_i,
   output logic                  C_ready_o,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic                  valid_o,
   input  logic                  ready_i
);

   arbState_t             r_state;
   arbState_t             w_stateNext;
   logic [1:0]            r_lockId;
   logic [1:0]            w_lockIdNext;
   logic [1:0]            r_rrPtr;
   logic [1:0]            w_rrPtrNext;
   logic                  r_valid;
   logic [DATA_WIDTH-1:0] r_data;

   logic [2:0]            w_req;
   logic [2:0]            w_pickOneHot;
   logic [1:0]            w_pickIdx;
   logic                  w_pickAny;
   logic [2:0]            w_selOneHot;
   logic                  w_selValid;
   logic [DATA_WIDTH-1:0] w_selData;
   logic                  w_space;
   logic                  w_xfer;
   logic                  w_isTail;

   assign w_req = {C_valid_i, B_valid_i, A_valid_i};

   rr_pick3 u_pick (
      .i_req        (w_req),
      .i_ptr        (r_rrPtr),
      .i_rr_en      (RR_EN != 0),
      .o_gnt_onehot (w_pickOneHot),
      .o_gnt_idx    (w_pickIdx),
      .o_any        (w_pickAny)
   );

   // Readies are forced low while reset is held so nothing is accepted then.
   assign w_space = rstn & (~r_valid | ready_i);

   // In LOCK only the owner is selected; in IDLE the picker's winner, if any.
   always_comb begin
      w_selOneHot = 3'b000;
      if (r_state == ST_LOCK) begin
         case (r_lockId)
            REQ_B:   w_selOneHot = 3'b010;
            REQ_C:   w_selOneHot = 3'b100;
            default: w_selOneHot = 3'b001;
         endcase
      end else if (w_pickAny) begin
         w_selOneHot = w_pickOneHot;
      end
   end

   // Route the selected requester's valid and flit toward the output register.
   always_comb begin
      w_selValid = 1'b0;
      w_selData  = A_data_i;
      if (w_selOneHot[0]) begin
         w_selValid = A_valid_i;
         w_selData  = A_data_i;
      end else if (w_selOneHot[1]) begin
         w_selValid = B_valid_i;
         w_selData  = B_data_i;
      end else if (w_selOneHot[2]) begin
         w_selValid = C_valid_i;
         w_selData  = C_data_i;
      end
   end

   assign A_ready_o = w_selOneHot[0] & w_space;
   assign B_ready_o = w_selOneHot[1] & w_space;
   assign C_ready_o = w_selOneHot[2] & w_space;
   assign w_xfer    = w_selValid & w_space;
   assign w_isTail  = (flitType(w_selData) == TAIL);

   // Next-state logic: lock on a multi-flit head, release on the owner's TAIL.
   always_comb begin
      w_stateNext  = r_state;
      w_lockIdNext = r_lockId;
      w_rrPtrNext  = r_rrPtr;
      case (r_state)
         ST_IDLE: begin
            if (w_xfer) begin
               if (!w_isTail) begin
                  w_stateNext  = ST_LOCK;
                  w_lockIdNext = w_pickIdx;
               end
               if (RR_EN != 0) begin
                  w_rrPtrNext = wrap3(w_pickIdx, 2'd1);
               end
            end
         end
         ST_LOCK: begin
            if (w_xfer && w_isTail) begin
               w_stateNext = ST_IDLE;
            end
         end
         default: w_stateNext = ST_IDLE;
      endcase
   end

   // Arbitration state, owner and round-robin pointer registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state  <= ST_IDLE;
         r_lockId <= 2'd0;
         r_rrPtr  <= 2'd0;
      end else begin
         r_state  <= w_stateNext;
         r_lockId <= w_lockIdNext;
         r_rrPtr  <= w_rrPtrNext;
      end
   end

   // Output stage: load on transfer, drain when downstream takes the flit.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end else if (w_xfer) begin
         r_valid <= 1'b1;
         r_data  <= w_selData;
      end else if (ready_i) begin
         r_valid <= 1'b0;
      end
   end

   assign data_o  = r_data;
   assign valid_o = r_valid;

endmodule

// File: tb/tb_arb_three.sv
// Directed scoreboard bench for arb_three: requester queues feed the inputs,
// expected flits are queued in arbitration order and popped at the output.
`timescale 1ns/1ps
module tb_arb_three;
   import arb_three_pkg::*;

   localparam int W = DATA_WIDTH;

   logic         clk = 1'b0;
   logic         rstn = 1'b0;
   logic [W-1:0] A_data_i, B_data_i, C_data_i, data_o;
   logic         A_valid_i, B_valid_i, C_valid_i;
   logic         A_ready_o, B_ready_o, C_ready_o;
   logic         valid_o, ready_i;

   logic [W-1:0] fpA_data, fpB_data, fpC_data, fp_data_o;
   logic         fpA_valid, fpB_valid, fpC_valid;
   logic         fpA_ready, fpB_ready, fpC_ready;
   logic         fp_valid_o, fpReady;

   int           errCount = 0;
   int           checkCount = 0;
   logic [W-1:0] srcA[$], srcB[$], srcC[$], expQ[$];
   logic         accA, accB, accC;
   logic [W-1:0] held;
   logic [7:0]   pat;

   always #5 clk = ~clk;

   arb_three #(.RR_EN(1), .OUT_ID(LOCAL)) dut (
      .clk(clk), .rstn(rstn),
      .A_data_i(A_data_i), .A_valid_i(A_valid_i), .A_ready_o(A_ready_o),
      .B_data_i(B_data_i), .B_valid_i(B_valid_i), .B_ready_o(B_ready_o),
      .C_data_i(C_data_i), .C_valid_i(C_valid_i), .C_ready_o(C_ready_o),
      .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i)
   );

   arb_three #(.RR_EN(0), .OUT_ID(NORTH)) uFixed (
      .clk(clk), .rstn(rstn),
      .A_data_i(fpA_data), .A_valid_i(fpA_valid), .A_ready_o(fpA_ready),
      .B_data_i(fpB_data), .B_valid_i(fpB_valid), .B_ready_o(fpB_ready),
      .C_data_i(fpC_data), .C_valid_i(fpC_valid), .C_ready_o(fpC_ready),
      .data_o(fp_data_o), .valid_o(fp_valid_o), .ready_i(fpReady)
   );

   function automatic logic [W-1:0] mkFlit(input logic [1:0] t, input int p);
      return {t, p[W-3:0]};
   endfunction

   function automatic logic [W-1:0] pktFlit(input int base, input int k, input int len);
      logic [1:0] t;
      if (k == len - 1)  t = TAIL;
      else if (k == 0)   t = HEAD;
      else               t = BODY;
      return mkFlit(t, base + k);
   endfunction

   task automatic checkOutput(input string tag, input logic [W-1:0] observed, input logic [W-1:0] expected);
      checkCount++;
      assert (observed === expected) else begin
         errCount++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic addPacket(input int who, input int base, input int len);
      for (int k = 0; k < len; k++) begin
         case (who)
            0:       srcA.push_back(pktFlit(base, k, len));
            1:       srcB.push_back(pktFlit(base, k, len));
            default: srcC.push_back(pktFlit(base, k, len));
         endcase
      end
   endtask

   task automatic addExpected(input int base, input int len);
      for (int k = 0; k < len; k++) expQ.push_back(pktFlit(base, k, len));
   endtask

   // One clock: note handshakes, then present each requester's next flit.
   task automatic applyStimulus();
      @(negedge clk);
      accA = A_valid_i & A_ready_o;
      accB = B_valid_i & B_ready_o;
      accC = C_valid_i & C_ready_o;
      @(posedge clk);
      #1;
      if (accA) void'(srcA.pop_front());
      if (accB) void'(srcB.pop_front());
      if (accC) void'(srcC.pop_front());
      A_valid_i = (srcA.size() != 0);
      A_data_i  = (srcA.size() != 0) ? srcA[0] : '0;
      B_valid_i = (srcB.size() != 0);
      B_data_i  = (srcB.size() != 0) ? srcB[0] : '0;
      C_valid_i = (srcC.size() != 0);
      C_data_i  = (srcC.size() != 0) ? srcC[0] : '0;
      #1;
   endtask

   task automatic drain(input string tag);
      int n = 0;
      while ((srcA.size() + srcB.size() + srcC.size() + expQ.size()) != 0 && n < 100) begin
         applyStimulus();
         n++;
      end
      checkOutput(tag, 32'(srcA.size() + srcB.size() + srcC.size() + expQ.size()), 32'd0);
   endtask

   // Output scoreboard: every downstream transfer must match the next entry.
   always @(negedge clk) begin
      if (rstn && valid_o && ready_i) begin
         if (expQ.size() == 0) begin
            checkCount++;
            errCount++;
            $error("[TB] FAIL sbUnderflow observed=%h expected=none", data_o);
         end else begin
            checkOutput("sbFlit", data_o, expQ.pop_front());
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      A_valid_i = 0; B_valid_i = 0; C_valid_i = 0;
      A_data_i = '0; B_data_i = '0; C_data_i = '0;
      ready_i = 0;
      fpA_valid = 0; fpB_valid = 0; fpC_valid = 0;
      fpA_data = '0; fpB_data = '0; fpC_data = '0; fpReady = 0;

      #12;
      checkOutput("rstValid", valid_o, 0);
      checkOutput("rstData", data_o, 0);
      checkOutput("rstReadies", {A_ready_o, B_ready_o, C_ready_o}, 0);
      @(posedge clk); #2; rstn = 1;
      applyStimulus(); applyStimulus();
      checkOutput("idleValid", valid_o, 0);
      checkOutput("idleData", data_o, 0);
      checkOutput("idleReadies", {A_ready_o, B_ready_o, C_ready_o}, 0);

      $display("[TB] single 3-flit packet from B");
      ready_i = 1;
      addPacket(1, 'h100, 3); addExpected('h100, 3);
      applyStimulus();
      checkOutput("bReadyHead", {A_ready_o, B_ready_o, C_ready_o}, 3'b010);
      drain("bDrain");
      checkOutput("bValidAfter", valid_o, 0);

      $display("[TB] ptr=2 with all three valid: C, A, B");
      addPacket(0, 'h200, 1); addPacket(1, 'h210, 1); addPacket(2, 'h220, 1);
      addExpected('h220, 1); addExpected('h200, 1); addExpected('h210, 1);
      drain("ptrDrain");
      addPacket(2, 'h230, 1); addExpected('h230, 1);
      drain("cAloneDrain");

      $display("[TB] contention, 2-flit packets, ptr=0");
      addPacket(0, 'h300, 2); addPacket(1, 'h310, 2); addPacket(2, 'h320, 2);
      addExpected('h300, 2); addExpected('h310, 2); addExpected('h320, 2);
      drain("contDrain");

      $display("[TB] lock hold: A owns the port while C waits");
      addPacket(0, 'h400, 6); addPacket(2, 'h410, 1);
      addExpected('h400, 6); addExpected('h410, 1);
      applyStimulus();
      for (int n = 0; n < 20 && srcA.size() != 0; n++) begin
         checkOutput("lockCReady", C_ready_o, 0);
         applyStimulus();
      end
      checkOutput("lockCWins", C_ready_o, 1);
      drain("lockDrain");

      $display("[TB] backpressure during a B packet");
      addPacket(1, 'h500, 4); addExpected('h500, 4);
      applyStimulus();
      pat = 8'b1111_1001;
      for (int i = 0; i < 8; i++) begin
         ready_i = pat[i];
         #1;
         if (!ready_i && valid_o) begin
            checkOutput("bpReadies", {A_ready_o, B_ready_o, C_ready_o}, 0);
            held = data_o;
            applyStimulus();
            checkOutput("bpHold", data_o, held);
            checkOutput("bpValidHold", valid_o, 1);
         end else begin
            applyStimulus();
         end
      end
      drain("bpDrain");

      $display("[TB] asynchronous reset mid-packet");
      addPacket(0, 'h600, 4);
      applyStimulus(); applyStimulus();
      #2; rstn = 0; #1;
      checkOutput("midRstValid", valid_o, 0);
      checkOutput("midRstData", data_o, 0);
      checkOutput("midRstReadies", {A_ready_o, B_ready_o, C_ready_o}, 0);
      srcA.delete(); srcB.delete(); srcC.delete(); expQ.delete();
      A_valid_i = 0; B_valid_i = 0; C_valid_i = 0;
      @(posedge clk); #2; rstn = 1;
      applyStimulus();
      checkOutput("postRstValid", valid_o, 0);
      addPacket(0, 'h700, 1); addPacket(1, 'h710, 1); addPacket(2, 'h720, 1);
      addExpected('h700, 1); addExpected('h710, 1); addExpected('h720, 1);
      drain("postRstOrder");

      $display("[TB] fixed priority: A starves C");
      fpReady = 1; fpA_valid = 1; fpC_valid = 1;
      for (int k = 0; k < 6; k++) begin
         fpA_data = mkFlit(TAIL, 'h800 + k);
         fpC_data = mkFlit(TAIL, 'h8F0);
         #1;
         checkOutput("fpCStarved", fpC_ready, 0);
         checkOutput("fpAReady", fpA_ready, 1);
         @(posedge clk); #1;
         checkOutput("fpData", fp_data_o, mkFlit(TAIL, 'h800 + k));
      end

      $display("Result: errors=%0d of %0d checks", errCount, checkCount);
      $finish;
   end

endmodule
